// File: rtl/vending_pkg.sv
// Shared vending definitions: controller state encoding and coin values,
// imported by both the change dispenser and the vending machine controller.
package vending_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    PULSE,
    GAP,
    DONE,
    ERROR
  } state_t;

  localparam logic [3:0] COIN_1 = 4'd1;
  localparam logic [3:0] COIN_2 = 4'd2;

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
// Loading N-1 therefore yields an expire flag on the Nth cycle after the load.
module pulse_timer #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/change_dispenser.sv
// Pays out change using 2-unit coins first, falling back to 1-unit coins,
// with fixed-width eject pulses separated by idle gaps.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] amount,
  input  logic       empty_1,
  input  logic       empty_2,
  output logic       eject_1,
  output logic       eject_2,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] remaining
);

  localparam int unsigned TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  state_t          state, state_next;
  logic [3:0]      rem_next;
  logic            coin_two, coin_two_next;
  logic            error_next;
  logic            timer_load;
  logic [TW-1:0]   timer_value;
  logic            timer_expired;
  logic [3:0]      coin_value;

  pulse_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (timer_load),
    .value  (timer_value),
    .expired(timer_expired)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      remaining <= '0;
      coin_two  <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_next;
      remaining <= rem_next;
      coin_two  <= coin_two_next;
      error     <= error_next;
    end
  end

  assign coin_value = coin_two ? COIN_2 : COIN_1;

  // Hopper flags are only looked at in SELECT, so a hopper emptying mid-coin
  // never cuts the current pulse short.
  always_comb begin
    state_next    = state;
    rem_next      = remaining;
    coin_two_next = coin_two;
    error_next    = error;
    timer_load    = 1'b0;
    timer_value   = '0;
    case (state)
      IDLE: begin
        if (start) begin
          rem_next   = amount;
          error_next = 1'b0;
          state_next = SELECT;
        end
      end
      SELECT: begin
        if (remaining == '0) begin
          state_next = DONE;
        end else if (remaining >= COIN_2 && !empty_2) begin
          coin_two_next = 1'b1;
          timer_load    = 1'b1;
          timer_value   = TW'(PULSE_CYCLES - 1);
          state_next    = PULSE;
        end else if (!empty_1) begin
          coin_two_next = 1'b0;
          timer_load    = 1'b1;
          timer_value   = TW'(PULSE_CYCLES - 1);
          state_next    = PULSE;
        end else begin
          error_next = 1'b1;
          state_next = ERROR;
        end
      end
      PULSE: begin
        if (timer_expired) begin
          rem_next    = remaining - coin_value;
          timer_load  = 1'b1;
          timer_value = TW'(GAP_CYCLES - 1);
          state_next  = GAP;
        end
      end
      GAP: begin
        if (timer_expired) begin
          state_next = SELECT;
        end
      end
      DONE:    state_next = IDLE;
      ERROR:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign eject_2 = (state == PULSE) &&  coin_two;
  assign eject_1 = (state == PULSE) && !coin_two;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

endmodule
